ctrl_fac_win_gen: RTL
=====================

# ctrl_fac_win_gen

Parametrised frame/window sequencer for the FFT datapath control chain. It replaces the fixed 16-count controller used ahead of the fac8 stage. On a start request it runs one frame of `FRAME_LEN` cycles and emits a one-cycle `alert_o` to the downstream module at frame start. It raises `valid_o` over a programmable window inside the frame, and also provides a window index, a frame-done strobe and a frame counter. A continuous mode chains frames back-to-back without an idle gap.

## Interface
- `CNT_WIDTH`, 4: width of the in-frame counter; requires 2^CNT_WIDTH ≥ FRAME_LEN.
- `FRAME_LEN`, 16: cycles per frame, ≥ 2.
- `VALID_START`, 8: first in-frame cycle index with `valid_o` high.
- `VALID_LEN`, 8: number of `valid_o` cycles; requires ≥ 1 and VALID_START+VALID_LEN ≤ FRAME_LEN.
- `FCNT_WIDTH`, 8: width of `frame_cnt`.
- `clk` input 1: single clock, rising edge.
- `rstn` input 1: asynchronous active-low reset.
- `en` input 1: start request, level-sampled.
- `mode_cont` input 1: 1 = continuous (back-to-back) frames; 0 = single frame with idle gap.
- `clr` input 1: synchronous abort/clear, active high.
- `valid_o` output 1: window-valid, registered.
- `alert_o` output 1: one-cycle frame-start pulse to the next module, registered.
- `busy` output 1: high in every cycle of an active frame.
- `frame_done` output 1: high in the last cycle of each frame.
- `win_idx` output CNT_WIDTH: position within the valid window; 0 outside the window.
- `frame_cnt` output FCNT_WIDTH: completed-frame count, wraps modulo 2^FCNT_WIDTH.

## Operation
- States:
  - IDLE: no frame active.
  - RUN: frame active, internal counter `cnt` in 0..FRAME_LEN-1.
- Cycle k of a frame is the k-th cycle after the start edge. In cycle k, `cnt` = k.
- IDLE → RUN:
  - Condition: `en`=1 and `clr`=0 sampled at a rising edge.
  - The next cycle is k=0.
- RUN in cycles 0..FRAME_LEN-2: `cnt` increments by 1 per cycle; `en` is ignored.
- RUN, last cycle (k=FRAME_LEN-1), transition taken at the following edge:
  - If `mode_cont`=1 and `en`=1 are sampled there, a new frame starts (k=0) immediately.
  - Otherwise the block goes to IDLE.
- In IDLE, `en` is sampled from the first idle cycle onward. So in single-frame mode the minimum start-to-start period is FRAME_LEN+1 cycles.
- Outputs in cycle k of a frame:
  - `alert_o`=1 only when k=0.
  - `valid_o`=1 exactly when VALID_START ≤ k ≤ VALID_START+VALID_LEN-1.
  - `win_idx`=k-VALID_START while `valid_o`=1, else 0.
  - `busy`=1 for all k.
  - `frame_done`=1 only when k=FRAME_LEN-1.
- All outputs are registers: the logic decodes next-state/next-count so values align with cycle k. There are no combinational paths from inputs to outputs.
- `frame_cnt` increments by 1 at the edge that ends each completed frame, visible from the following cycle. It wraps from 2^FCNT_WIDTH-1 to 0.
- `clr`=1 at an edge, in any state:
  - Next state is IDLE and `frame_cnt` is cleared to 0.
  - All outputs are 0 from the next cycle.
  - `clr` has priority over `en`, including a simultaneous start.
  - An aborted frame does not increment `frame_cnt` and produces no `frame_done`.
- Parameter violations (listed in Interface) are elaboration-time errors via `$error` in an initial/generate check.

## Timing
- Reset: `rstn`=0 immediately forces IDLE, `cnt`=0, and all outputs (`valid_o`, `alert_o`, `busy`, `frame_done`, `win_idx`, `frame_cnt`) to 0, independent of `clk`.
- Reset asserted mid-frame aborts the frame with no `frame_done`.
- After reset release, the first start needs `en`=1 at a rising edge.
- Latency: `en` sampled at edge E0 → `alert_o` in the cycle after E0.
  - `valid_o` rises VALID_START cycles later and stays high for VALID_LEN cycles.
  - `frame_done` is high FRAME_LEN-1 cycles after `alert_o`.
- Defaults: `alert_o` in cycle 0, `valid_o` in cycles 8..15, `frame_done` in cycle 15, `busy` in cycles 0..15.
  - Single-frame mode with `en` held high: next `alert_o` in cycle 17 (cycle 16 is idle).
  - Continuous mode with `en` held high: next `alert_o` in cycle 16, period 16.
- In continuous mode, dropping `en` before the last-cycle edge ends the chain after the current frame completes.
- When `valid_o` reaches the last frame cycle (VALID_START+VALID_LEN=FRAME_LEN) and a continuous restart occurs, `valid_o` falls and `alert_o` rises in the same cycle with no gap.

## Test plan
- Defaults, single pulse of `en`: `alert_o` in cycle 0 only; `valid_o` in cycles 8..15 with `win_idx` 0..7; `frame_done` in cycle 15; `frame_cnt` reads 1 from cycle 16; all outputs 0 in cycle 16.
- Defaults, `en` held high, `mode_cont`=0 then 1:
  - `mode_cont`=0: `alert_o` period 17.
  - `mode_cont`=1: period 16 with `busy` continuously 1.
  - After 3 continuous frames `frame_cnt`=3.
- FRAME_LEN=8, CNT_WIDTH=3, VALID_START=2, VALID_LEN=6, `mode_cont`=1: `valid_o` in cycles 2..7; in the following cycle `valid_o`=0, `alert_o`=1 and `win_idx`=0.
- `clr` at cycle 10 of a default frame, with `en`=1 at the same edge: from cycle 11 all outputs 0 and `frame_cnt`=0; no restart. `en` at the next edge starts a frame normally.
- `rstn` pulsed low asynchronously mid-cycle during cycle 12: outputs 0 immediately, no `frame_done`. After release plus `en`, a full default frame is produced.
- FCNT_WIDTH=2, 5 continuous frames: `frame_cnt` sequence 1,2,3,0,1.

Source files
------------

// File: rtl/ctrl_fac_win_gen.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_fac_win_gen
// Brief    : Frame/window sequencer for the FFT control chain. Runs frames of
//            FRAME_LEN cycles, pulses alert_o at frame start, raises valid_o
//            over a programmable window and counts completed frames.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_fac_win_gen #(
  parameter int CNT_WIDTH   = 4,
  parameter int FRAME_LEN   = 16,
  parameter int VALID_START = 8,
  parameter int VALID_LEN   = 8,
  parameter int FCNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  mode_cont,
  input  logic                  clr,
  output logic                  valid_o,
  output logic                  alert_o,
  output logic                  busy,
  output logic                  frame_done,
  output logic [CNT_WIDTH-1:0]  win_idx,
  output logic [FCNT_WIDTH-1:0] frame_cnt
);

  // Bad parameter sets are rejected at elaboration.
  if (CNT_WIDTH < 1 || CNT_WIDTH > 31) begin : g_bad_cnt_width
    $error("ctrl_fac_win_gen: CNT_WIDTH must be in 1..31");
  end
  if (FRAME_LEN < 2) begin : g_bad_frame_len
    $error("ctrl_fac_win_gen: FRAME_LEN must be >= 2");
  end
  if ((1 << CNT_WIDTH) < FRAME_LEN) begin : g_bad_cnt_range
    $error("ctrl_fac_win_gen: 2**CNT_WIDTH must be >= FRAME_LEN");
  end
  if (VALID_START < 0 || VALID_LEN < 1) begin : g_bad_window
    $error("ctrl_fac_win_gen: VALID_START must be >= 0 and VALID_LEN >= 1");
  end
  if (VALID_START + VALID_LEN > FRAME_LEN) begin : g_bad_window_end
    $error("ctrl_fac_win_gen: window must fit inside the frame");
  end
  if (FCNT_WIDTH < 1) begin : g_bad_fcnt_width
    $error("ctrl_fac_win_gen: FCNT_WIDTH must be >= 1");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(FRAME_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] WIN_BASE = CNT_WIDTH'(VALID_START);
  localparam logic [31:0]          WIN_LO   = 32'(VALID_START);
  localparam logic [31:0]          WIN_LEN  = 32'(VALID_LEN);

  state_t                 state;
  state_t                 state_n;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [CNT_WIDTH-1:0]   cnt_n;
  logic                   frame_end;
  logic                   run_n;
  logic [31:0]            cnt_n_ext;
  logic                   in_win_n;
  logic [CNT_WIDTH-1:0]   win_idx_n;

  // Next state / next count; clr overrides everything, including a start.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    frame_end = 1'b0;
    if (clr) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_n = '0;
          if (en) begin
            state_n = RUN;
          end
        end
        RUN: begin
          if (cnt == LAST_CNT) begin
            frame_end = 1'b1;
            cnt_n     = '0;
            state_n   = (mode_cont && en) ? RUN : IDLE;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // Decode outputs from the next count so the registered values line up
  // with in-frame cycle k. The window test uses an unsigned-wrap range check.
  assign run_n     = (state_n == RUN);
  assign cnt_n_ext = {{(32-CNT_WIDTH){1'b0}}, cnt_n};
  assign in_win_n  = run_n && ((cnt_n_ext - WIN_LO) < WIN_LEN);
  assign win_idx_n = in_win_n ? (cnt_n - WIN_BASE) : '0;

  // State, counter and all outputs are registered here.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      alert_o    <= 1'b0;
      valid_o    <= 1'b0;
      frame_done <= 1'b0;
      win_idx    <= '0;
      frame_cnt  <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      busy       <= run_n;
      alert_o    <= run_n && (cnt_n == '0);
      valid_o    <= in_win_n;
      frame_done <= run_n && (cnt_n == LAST_CNT);
      win_idx    <= win_idx_n;
      if (clr) begin
        frame_cnt <= '0;
      end else if (frame_end) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
